rng_roll_scheduler: RTL

Sequences the board's random-roll display. On a start press it issues a decelerating series of sample strobes to the free-running random source. It latches the source value on each strobe and presents it to the 7-seg/LED path. After the final strobe it freezes the value and reports completion. It sits between the debounced key inputs and the random-counter datapath in the DE2-115 top level.

---
 rtl/rng_roll_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/rng_roll_scheduler.sv
// Random-roll sequencer: decelerating sample strobes into a free-running random source, freeze, done pulse.
// Optional: define RNG_RETRIGGER_EN to let a start edge during a roll restart the schedule.
module rng_roll_scheduler #(
  parameter int unsigned TICK_DIV  = 5000000,
  parameter int unsigned NUM_STEPS = 16,
  parameter int unsigned RAND_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [RAND_W-1:0] i_rand,
  output logic              o_sample,
  output logic [RAND_W-1:0] o_value,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic [31:0]       cnt, cnt_nxt;
  logic              start_d, stop_d;
  logic              start_edge, stop_edge;
  logic              terminal;
  logic              sample_nxt, value_load;

  // Last count value of step k: TICK_DIV * m(k) - 1, with m slowing the roll toward the end.
  function automatic logic [31:0] interval_last(input logic [STEP_W-1:0] k);
    logic [31:0] kk;
    logic [31:0] m;
    kk = 32'(k);
    if (kk <= 32'd9)       m = 32'd1;
    else if (kk <= 32'd12) m = 32'd2;
    else if (kk <= 32'd14) m = 32'd4;
    else                   m = 32'd10;
    return 32'(TICK_DIV) * m - 32'd1;
  endfunction

  assign start_edge = i_start & ~start_d;
  assign stop_edge  = i_stop  & ~stop_d;
  assign terminal   = (cnt == interval_last(step));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_nxt  = state;
    step_nxt   = step;
    cnt_nxt    = cnt;
    sample_nxt = 1'b0;
    value_load = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = ROLL;
          step_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      ROLL: begin
        cnt_nxt = cnt + 32'd1;
        if (terminal) begin
          sample_nxt = 1'b1;
          value_load = 1'b1;
          cnt_nxt    = '0;
          if (step == LAST_STEP) state_nxt = DONE;
          else                   step_nxt  = step + 1'b1;
        end
        // Early stop jumps to the final (longest) interval; during the final step it has no effect.
        if (stop_edge && (step != LAST_STEP)) begin
          step_nxt = LAST_STEP;
          cnt_nxt  = '0;
        end
`ifdef RNG_RETRIGGER_EN
        if (start_edge) begin
          state_nxt = ROLL;
          step_nxt  = '0;
          cnt_nxt   = '0;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      step     <= '0;
      cnt      <= '0;
      start_d  <= 1'b0;
      stop_d   <= 1'b0;
      o_sample <= 1'b0;
      o_value  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      cnt      <= cnt_nxt;
      start_d  <= i_start;
      stop_d   <= i_stop;
      o_sample <= sample_nxt;
      o_busy   <= (state_nxt != IDLE);
      o_done   <= (state == DONE);
      if (value_load) o_value <= i_rand;
    end
  end

endmodule
